// File: rtl/burst_fsm_pkg.sv
//============================================================================
// Module   : burst_fsm_pkg
// Desc     : Shared state encoding for the burst on-transit tracker.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package burst_fsm_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] C_ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] C_ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] C_ST_LAST = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_RUN  = C_ST_RUN,
        ST_LAST = C_ST_LAST
    } state_t;

endpackage

`default_nettype wire

// File: rtl/burst_ontransit.sv
//============================================================================
// Module   : burst_ontransit
// Desc     : Tracks bursts of do_in activity and emits registered
//            start / continue / end / overflow / abort pulses plus length.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module burst_ontransit
    import burst_fsm_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int MAX_LEN = 16,
    parameter int GAP     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             do_in,   // activity qualifier ("do" is a reserved word)
    input  logic             abort,
    output logic             start,
    output logic             s,
    output logic             g,
    output logic             ovf,
    output logic             abrt,
    output logic [CNT_W-1:0] len,
    output logic             busy
);

    localparam int                GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0]  C_GAP_END = GAP_W'(GAP - 1);
    localparam logic [CNT_W-1:0]  C_MAX_LEN = CNT_W'(MAX_LEN);

    generate
        if ((MAX_LEN < 1) || (longint'(MAX_LEN) > ((longint'(1) << CNT_W) - 1)) || (GAP < 1)) begin : g_param_err
            $error("burst_ontransit: MAX_LEN must be 1..2^CNT_W-1 and GAP must be >= 1");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len_nxt;
    logic             r_start, r_s, r_g, r_ovf, r_abrt;
    logic             w_start_nxt, w_s_nxt, w_g_nxt, w_ovf_nxt, w_abrt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_len_nxt   = r_len;
        w_start_nxt = 1'b0;
        w_s_nxt     = 1'b0;
        w_g_nxt     = 1'b0;
        w_ovf_nxt   = 1'b0;
        w_abrt_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (do_in && !abort) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_W'(1);
                    w_start_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_abrt_nxt  = 1'b1;
                end else if (!do_in) begin
                    w_state_nxt = ST_LAST;
                    w_len_nxt   = r_cnt;
                    w_cnt_nxt   = '0;
                    w_gap_nxt   = '0;
                    w_g_nxt     = 1'b1;
                end else if (r_cnt == C_MAX_LEN) begin
                    // The do-high cycle that hits the limit is not counted.
                    w_state_nxt = ST_LAST;
                    w_len_nxt   = C_MAX_LEN;
                    w_cnt_nxt   = '0;
                    w_gap_nxt   = '0;
                    w_g_nxt     = 1'b1;
                    w_ovf_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_s_nxt     = 1'b1;
                end
            end
            ST_LAST: begin
                if (r_gap_cnt == C_GAP_END) begin
                    w_state_nxt = ST_IDLE;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt   = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
            r_s     <= 1'b0;
            r_g     <= 1'b0;
            r_ovf   <= 1'b0;
            r_abrt  <= 1'b0;
            r_len   <= '0;
        end else begin
            r_start <= w_start_nxt;
            r_s     <= w_s_nxt;
            r_g     <= w_g_nxt;
            r_ovf   <= w_ovf_nxt;
            r_abrt  <= w_abrt_nxt;
            r_len   <= w_len_nxt;
        end
    end

    assign start = r_start;
    assign s     = r_s;
    assign g     = r_g;
    assign ovf   = r_ovf;
    assign abrt  = r_abrt;
    assign len   = r_len;
    assign busy  = (r_state != ST_IDLE);

`ifndef SYNTHESIS
    // Readable state name for waveform viewers.
    logic [8*4-1:0] w_state_ascii_unused;
    always_comb begin
        case (r_state)
            ST_IDLE: w_state_ascii_unused = "IDLE";
            ST_RUN:  w_state_ascii_unused = "RUN ";
            ST_LAST: w_state_ascii_unused = "LAST";
            default: w_state_ascii_unused = "????";
        endcase
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_burst_ontransit.sv
//============================================================================
// Module   : tb_burst_ontransit
// Desc     : Scoreboard bench; dut_a uses defaults, dut_b MAX_LEN=4 GAP=3.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_burst_ontransit;

    localparam logic [4:0] EV_NONE  = 5'b00000;
    localparam logic [4:0] EV_START = 5'b10000;
    localparam logic [4:0] EV_S     = 5'b01000;
    localparam logic [4:0] EV_G     = 5'b00100;
    localparam logic [4:0] EV_OVF   = 5'b00110;
    localparam logic [4:0] EV_ABRT  = 5'b00001;

    typedef struct {
        logic [4:0] vec;
        logic [7:0] len;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       do_a = 1'b0, abort_a = 1'b0, do_b = 1'b0, abort_b = 1'b0;
    logic       start_a, s_a, g_a, ovf_a, abrt_a, busy_a;
    logic       start_b, s_b, g_b, ovf_b, abrt_b, busy_b;
    logic [7:0] len_a, len_b;

    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    burst_ontransit dut_a (
        .clk(clk), .rst_n(rst_n), .do_in(do_a), .abort(abort_a),
        .start(start_a), .s(s_a), .g(g_a), .ovf(ovf_a), .abrt(abrt_a),
        .len(len_a), .busy(busy_a)
    );

    burst_ontransit #(.CNT_W(8), .MAX_LEN(4), .GAP(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .do_in(do_b), .abort(abort_b),
        .start(start_b), .s(s_b), .g(g_b), .ovf(ovf_b), .abrt(abrt_b),
        .len(len_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards: each expected pulse must appear on exactly the cycle it was scheduled for.
    always @(negedge clk) begin : mon_a
        exp_t       e;
        logic [4:0] v;
        v = {start_a, s_a, g_a, ovf_a, abrt_a};
        if (q_a.size() > 0 && q_a[0].at <= cyc) begin
            e = q_a.pop_front();
            n_total++;
            if (v !== e.vec || (e.vec[2] && len_a !== e.len))
                $display("FAIL sb_a cyc=%0d: got ev=%b len=%0d, expected ev=%b len=%0d", cyc, v, len_a, e.vec, e.len);
            else n_pass++;
        end else if (v !== EV_NONE) begin
            n_total++;
            $display("FAIL sb_a_unexpected cyc=%0d: got ev=%b, expected ev=%b", cyc, v, EV_NONE);
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t       e;
        logic [4:0] v;
        v = {start_b, s_b, g_b, ovf_b, abrt_b};
        if (q_b.size() > 0 && q_b[0].at <= cyc) begin
            e = q_b.pop_front();
            n_total++;
            if (v !== e.vec || (e.vec[2] && len_b !== e.len))
                $display("FAIL sb_b cyc=%0d: got ev=%b len=%0d, expected ev=%b len=%0d", cyc, v, len_b, e.vec, e.len);
            else n_pass++;
        end else if (v !== EV_NONE) begin
            n_total++;
            $display("FAIL sb_b_unexpected cyc=%0d: got ev=%b, expected ev=%b", cyc, v, EV_NONE);
        end
    end

    task automatic drive_a(input logic d, input logic ab, input logic [4:0] ev, input logic [7:0] l);
        exp_t e;
        if (ev != EV_NONE) begin
            e.vec = ev; e.len = l; e.at = cyc + 1;
            q_a.push_back(e);
        end
        do_a = d; abort_a = ab;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic d, input logic ab, input logic [4:0] ev, input logic [7:0] l);
        exp_t e;
        if (ev != EV_NONE) begin
            e.vec = ev; e.len = l; e.at = cyc + 1;
            q_b.push_back(e);
        end
        do_b = d; abort_b = ab;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({start_a, s_a, g_a, ovf_a, abrt_a, busy_a, len_a} !== 14'd0)
            $display("FAIL reset_a: got %h expected %h", {start_a, s_a, g_a, ovf_a, abrt_a, busy_a, len_a}, 14'd0);
        else n_pass++;
        n_total++;
        if ({start_b, s_b, g_b, ovf_b, abrt_b, busy_b, len_b} !== 14'd0)
            $display("FAIL reset_b: got %h expected %h", {start_b, s_b, g_b, ovf_b, abrt_b, busy_b, len_b}, 14'd0);
        else n_pass++;
        do_a = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({start_a, busy_a} !== 2'b00) $display("FAIL reset_hold: got %b expected %b", {start_a, busy_a}, 2'b00);
        else n_pass++;
        @(negedge clk);
        do_a = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive_a(1, 0, EV_START, 0);
        drive_a(1, 0, EV_S, 0);
        drive_a(1, 0, EV_S, 0);
        drive_a(0, 0, EV_G, 3);
        n_total++; if (busy_a !== 1'b1) $display("FAIL basic_busy_last0: got %b expected 1", busy_a); else n_pass++;
        drive_a(0, 0, EV_NONE, 0);
        n_total++; if (busy_a !== 1'b1) $display("FAIL basic_busy_last1: got %b expected 1", busy_a); else n_pass++;
        drive_a(0, 0, EV_NONE, 0);
        n_total++; if (busy_a !== 1'b0) $display("FAIL basic_busy_idle: got %b expected 0", busy_a); else n_pass++;
        n_total++; if (len_a !== 8'd3) $display("FAIL basic_len: got %0d expected 3", len_a); else n_pass++;
        #1;
        n_total++; if (q_a.size() != 0) $display("FAIL basic_pending: got %0d expected 0", q_a.size()); else n_pass++;
    endtask

    task automatic test_abort();
        drive_a(1, 0, EV_START, 0);
        drive_a(1, 0, EV_S, 0);
        drive_a(1, 1, EV_ABRT, 0);
        n_total++; if (busy_a !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy_a); else n_pass++;
        n_total++; if (len_a !== 8'd3) $display("FAIL abort_len: got %0d expected 3", len_a); else n_pass++;
        drive_a(0, 0, EV_NONE, 0);
        #1;
        n_total++; if (q_a.size() != 0) $display("FAIL abort_pending: got %0d expected 0", q_a.size()); else n_pass++;
    endtask

    task automatic test_idle_do_abort();
        for (int i = 0; i < 3; i++) begin
            drive_a(1, 1, EV_NONE, 0);
            n_total++;
            if ({start_a, busy_a} !== 2'b00) $display("FAIL idle_abort_%0d: got %b expected %b", i, {start_a, busy_a}, 2'b00);
            else n_pass++;
        end
        drive_a(0, 0, EV_NONE, 0);
    endtask

    task automatic test_overflow();
        // Exactly MAX_LEN do-high cycles: normal end, no overflow.
        drive_b(1, 0, EV_START, 0);
        for (int i = 0; i < 3; i++) drive_b(1, 0, EV_S, 0);
        drive_b(0, 0, EV_G, 4);
        for (int i = 0; i < 3; i++) drive_b(0, 0, EV_NONE, 0);
        n_total++; if (busy_b !== 1'b0) $display("FAIL exact_busy: got %b expected 0", busy_b); else n_pass++;
        // do held high: forced end on the 5th high cycle, restart once LAST drains.
        drive_b(1, 0, EV_START, 0);
        for (int i = 0; i < 3; i++) drive_b(1, 0, EV_S, 0);
        drive_b(1, 0, EV_OVF, 4);
        n_total++; if (busy_b !== 1'b1) $display("FAIL ovf_busy_last: got %b expected 1", busy_b); else n_pass++;
        drive_b(1, 0, EV_NONE, 0);
        drive_b(1, 0, EV_NONE, 0);
        n_total++; if (busy_b !== 1'b1) $display("FAIL ovf_busy_last2: got %b expected 1", busy_b); else n_pass++;
        drive_b(1, 0, EV_NONE, 0);
        n_total++; if (busy_b !== 1'b0) $display("FAIL ovf_busy_idle: got %b expected 0", busy_b); else n_pass++;
        drive_b(1, 0, EV_START, 0);
        drive_b(0, 0, EV_G, 1);
        for (int i = 0; i < 3; i++) drive_b(0, 0, EV_NONE, 0);
        n_total++; if (len_b !== 8'd1) $display("FAIL ovf_len_after: got %0d expected 1", len_b); else n_pass++;
        #1;
        n_total++; if (q_b.size() != 0) $display("FAIL ovf_pending: got %0d expected 0", q_b.size()); else n_pass++;
    endtask

    task automatic test_gap_toggle();
        drive_b(1, 0, EV_START, 0);
        drive_b(0, 0, EV_G, 1);
        drive_b(1, 0, EV_NONE, 0);
        drive_b(0, 1, EV_NONE, 0);
        n_total++; if (busy_b !== 1'b1) $display("FAIL gap_busy_last: got %b expected 1", busy_b); else n_pass++;
        drive_b(1, 0, EV_NONE, 0);
        n_total++; if (busy_b !== 1'b0) $display("FAIL gap_busy_idle: got %b expected 0", busy_b); else n_pass++;
        drive_b(1, 0, EV_START, 0);
        drive_b(1, 0, EV_S, 0);
        drive_b(0, 0, EV_G, 2);
        for (int i = 0; i < 3; i++) drive_b(0, 0, EV_NONE, 0);
        n_total++; if (len_b !== 8'd2) $display("FAIL gap_len: got %0d expected 2", len_b); else n_pass++;
        #1;
        n_total++; if (q_b.size() != 0) $display("FAIL gap_pending: got %0d expected 0", q_b.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive_a(1, 0, EV_START, 0);
        for (int i = 0; i < 4; i++) drive_a(1, 0, EV_S, 0);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({start_a, s_a, g_a, ovf_a, abrt_a, busy_a, len_a} !== 14'd0)
            $display("FAIL rstmid_outputs: got %h expected %h", {start_a, s_a, g_a, ovf_a, abrt_a, busy_a, len_a}, 14'd0);
        else n_pass++;
        @(negedge clk);
        do_a = 1'b1;
        rst_n = 1'b1;
        #1;
        n_total++;
        if ({start_a, busy_a} !== 2'b00) $display("FAIL rstmid_release: got %b expected %b", {start_a, busy_a}, 2'b00);
        else n_pass++;
        drive_a(1, 0, EV_START, 0);
        drive_a(0, 0, EV_G, 1);
        drive_a(0, 0, EV_NONE, 0);
        drive_a(0, 0, EV_NONE, 0);
        n_total++; if (busy_a !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy_a); else n_pass++;
        n_total++; if (len_a !== 8'd1) $display("FAIL rstmid_len: got %0d expected 1", len_a); else n_pass++;
        #1;
        n_total++; if (q_a.size() != 0) $display("FAIL rstmid_pending: got %0d expected 0", q_a.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_idle_do_abort();
        test_overflow();
        test_gap_toggle();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/burst_ontransit.md
BURST_ONTRANSIT -- requirements
Module: burst_ontransit

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of burst counter and len output.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum counted do-high cycles per burst (1..2^CNT_W-1).
REQ-003 SHALL have parameter GAP, default 2, cycles spent in LAST before IDLE (>=1).
REQ-004 SHALL have port clk  input  1  clock, all flops on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port do  input  1  activity qualifier.
REQ-007 SHALL have port abort  input  1  cancel current burst.
REQ-008 SHALL have port start  output  1  registered pulse, burst began.
REQ-009 SHALL have port s  output  1  registered pulse, burst continued one cycle.
REQ-010 SHALL have port g  output  1  registered pulse, burst ended (normal or overflow).
REQ-011 SHALL have port ovf  output  1  registered pulse, burst forced to end at MAX_LEN.
REQ-012 SHALL have port abrt  output  1  registered pulse, burst aborted.
REQ-013 SHALL have port len  output  CNT_W  length of last completed burst, held until next completion.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, RUN, LAST; internal counters cnt (CNT_W) and gap_cnt.
REQ-016 SHALL compute pulse outputs combinationally from state and inputs, registered at the same edge as the state update; each pulse lasts exactly one cycle, in the first cycle of the new state.
REQ-017 SHALL default all pulse next-values to 0 each cycle; only listed transitions assert them.
REQ-018 IDLE: do=1 and abort=0 -> RUN, start=1, cnt=1; otherwise stay IDLE, no pulse.
REQ-019 RUN: abort=1 (highest priority) -> IDLE, abrt=1, cnt=0, len unchanged.
REQ-020 RUN: do=0 -> LAST, g=1, len=cnt.
REQ-021 RUN: do=1 and cnt==MAX_LEN -> LAST, g=1, ovf=1, len=MAX_LEN; that do-high cycle is not counted.
REQ-022 RUN: do=1 and cnt<MAX_LEN -> stay RUN, s=1, cnt=cnt+1.
REQ-023 LAST: stay exactly GAP cycles, then IDLE; do and abort ignored throughout LAST.
REQ-024 A burst of N do-high cycles (N<=MAX_LEN) SHALL yield one start, N-1 s pulses, one g, len=N.
REQ-025 Counter SHALL never wrap; MAX_LEN>2^CNT_W-1 or GAP<1 SHALL be an elaboration error.
REQ-026 busy SHALL be decoded from the state register only (glitch-free).

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, cnt=0, gap_cnt=0, all pulses 0, len=0, busy=0.
REQ-028 Reset asserted mid-burst SHALL discard the burst with no g, ovf or abrt pulse on release.
REQ-029 First transition after reset release SHALL occur no earlier than the first rising clk edge.

Structure
REQ-030 State encoding constants (IDLE=0, RUN=1, LAST=2, 2-bit) SHALL live in shared package burst_fsm_pkg.
REQ-031 SHALL be a single module with no sub-modules; state register, transition block and output register as separate processes.
REQ-032 Simulation-only state-name decode SHALL be excluded under SYNTHESIS.

Verification
REQ-033 do high 3 cycles then low, defaults -> start, 2 s pulses, g, len=3, busy low 2 cycles after g.
REQ-034 MAX_LEN=4, do held high 8 cycles -> g and ovf together 4 cycles after start, len=4, new start after GAP.
REQ-035 abort=1 on 2nd RUN cycle -> abrt pulse, IDLE next, len keeps prior value, no g.
REQ-036 do and abort high in IDLE -> no start, busy stays 0.
REQ-037 rst_n low during RUN with cnt=5 -> all outputs 0 immediately, no pulses after release.
REQ-038 do toggling during LAST with GAP=3 -> exactly 3 LAST cycles, no start until IDLE reached.
